// File: rtl/uart_hamming_transmitter.sv
// UART transmitter for Hamming(7,4) codewords: start bit, 7 data bits LSB first, stop bit(s),
// 8 enabled clocks per bit, with a one-entry holding register for gap-free back-to-back frames.
module uart_hamming_transmitter #(
   parameter int ENCODE    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [6:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       tx,
   output logic       busy_out,
   output logic [2:0] state_out
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3
   } state_t;

   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   state_t     state, state_nx;
   logic [2:0] sample_cnt, sample_cnt_nx;
   logic [2:0] bit_cnt, bit_cnt_nx;
   logic [6:0] shifter, shifter_nx;
   logic [6:0] hold_data, cw_in;
   logic       hold_valid, hold_valid_nx;
   logic       tx_nx, load, accept;

   function automatic logic [6:0] hamming_encode(input logic [3:0] d);
      logic p1, p2, p3;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p3 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p3, d[0], p2, p1};
   endfunction

   assign cw_in     = (ENCODE != 0) ? hamming_encode(data_in[3:0]) : data_in;
   assign accept    = valid_in & ~hold_valid;
   assign ready_out = ~hold_valid;
   assign busy_out  = (state != IDLE) | hold_valid;
   assign state_out = state;

   always_comb begin
      state_nx      = state;
      sample_cnt_nx = sample_cnt;
      bit_cnt_nx    = bit_cnt;
      shifter_nx    = shifter;
      tx_nx         = tx;
      load          = 1'b0;
      case (state)
         IDLE: begin
            tx_nx         = 1'b1;
            sample_cnt_nx = 3'd0;
            bit_cnt_nx    = 3'd0;
            if (hold_valid) begin
               load       = 1'b1;
               shifter_nx = hold_data;
               state_nx   = START;
               tx_nx      = 1'b0;
            end
         end
         START: begin
            tx_nx         = 1'b0;
            sample_cnt_nx = sample_cnt + 3'd1;
            if (sample_cnt == 3'd7) begin
               state_nx   = DATA;
               bit_cnt_nx = 3'd0;
               tx_nx      = shifter[0];
            end
         end
         DATA: begin
            tx_nx         = shifter[0];
            sample_cnt_nx = sample_cnt + 3'd1;
            if (sample_cnt == 3'd7) begin
               if (bit_cnt == 3'd6) begin
                  state_nx   = STOP;
                  bit_cnt_nx = 3'd0;
                  tx_nx      = 1'b1;
               end else begin
                  shifter_nx = shifter >> 1;
                  tx_nx      = shifter[1];
                  bit_cnt_nx = bit_cnt + 3'd1;
               end
            end
         end
         STOP: begin
            tx_nx         = 1'b1;
            sample_cnt_nx = sample_cnt + 3'd1;
            if (sample_cnt == 3'd7) begin
               if (bit_cnt == LAST_STOP) begin
                  bit_cnt_nx = 3'd0;
                  // Chain straight into the next start bit when a word is waiting
                  if (hold_valid) begin
                     load       = 1'b1;
                     shifter_nx = hold_data;
                     state_nx   = START;
                     tx_nx      = 1'b0;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  bit_cnt_nx = bit_cnt + 3'd1;
               end
            end
         end
         default: begin
            state_nx      = IDLE;
            tx_nx         = 1'b1;
            sample_cnt_nx = 3'd0;
            bit_cnt_nx    = 3'd0;
         end
      endcase
   end

   // Hold can never be accepted and transferred on the same edge: transfer needs it full.
   assign hold_valid_nx = load ? 1'b0 : (accept ? 1'b1 : hold_valid);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         sample_cnt <= 3'd0;
         bit_cnt    <= 3'd0;
         tx         <= 1'b1;
         hold_valid <= 1'b0;
      end else if (ena) begin
         state      <= state_nx;
         sample_cnt <= sample_cnt_nx;
         bit_cnt    <= bit_cnt_nx;
         tx         <= tx_nx;
         hold_valid <= hold_valid_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (ena) begin
         shifter <= shifter_nx;
         if (accept) hold_data <= cw_in;
      end
   end

endmodule

// File: tb/tb_uart_hamming_transmitter.sv
// Directed bench for uart_hamming_transmitter: plain, encoding and two-stop-bit instances
// driven from shared stimulus, checked against hand-derived frame bit sequences.
module tb_uart_hamming_transmitter;

   logic       clk = 1'b0;
   logic       rst_n, ena, valid_in;
   logic [6:0] data_in;
   logic       ready0, tx0, busy0;
   logic       ready1, tx1, busy1;
   logic       ready2, tx2, busy2;
   logic [2:0] st0, st1, st2;
   logic       tx_sel;
   int         sel = 0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   uart_hamming_transmitter #(.ENCODE(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready0), .tx(tx0), .busy_out(busy0), .state_out(st0));

   uart_hamming_transmitter #(.ENCODE(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready1), .tx(tx1), .busy_out(busy1), .state_out(st1));

   uart_hamming_transmitter #(.ENCODE(0), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready2), .tx(tx2), .busy_out(busy2), .state_out(st2));

   assign tx_sel = (sel == 1) ? tx1 : (sel == 2) ? tx2 : tx0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ena = 1'b1; valid_in = 1'b0; data_in = 7'h00;
      step();
      rst_n = 1'b1;
   endtask

   // Called right after the load edge; checks every cycle of one frame.
   task automatic check_frame(input logic [6:0] word, input int stop_bits,
                              input bit toggle, input string name);
      int         cpb;
      int         idx;
      logic [9:0] bits;
      bit         okb;
      logic       seen;
      cpb  = toggle ? 16 : 8;
      bits = '1;
      bits[0] = 1'b0;
      for (int j = 0; j < 7; j++) bits[j+1] = word[j];
      idx = 0;
      for (int b = 0; b < 8 + stop_bits; b++) begin
         okb  = 1'b1;
         seen = bits[b];
         for (int c = 0; c < cpb; c++) begin
            if (tx_sel !== bits[b]) begin okb = 1'b0; seen = tx_sel; end
            idx++;
            if (toggle) ena = ((idx % 2) == 0);
            step();
         end
         total++;
         if (!okb) begin
            bad++;
            $display("FAIL %s bit%0d: tx=%b expected=%b", name, b, seen, bits[b]);
         end
      end
      ena = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; valid_in = 1'b0; data_in = 7'h00;
      step(); step();
      rst_n = 1'b1;
      total++;
      if ({tx0, st0, ready0, busy0} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset0: {tx,state,ready,busy}=%b expected=%b",
                  {tx0, st0, ready0, busy0}, {1'b1, 3'd0, 1'b1, 1'b0});
      end
      total++;
      if ({tx2, st2, ready2, busy2} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset2: {tx,state,ready,busy}=%b expected=%b",
                  {tx2, st2, ready2, busy2}, {1'b1, 3'd0, 1'b1, 1'b0});
      end
   endtask

   task automatic test_ena_gate();
      do_reset();
      ena = 1'b0; valid_in = 1'b1; data_in = 7'h4B;
      step(); step(); step();
      total++;
      if ({ready0, busy0, tx0, st0} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
         bad++;
         $display("FAIL ena_gate: {ready,busy,tx,state}=%b expected=%b",
                  {ready0, busy0, tx0, st0}, {1'b1, 1'b0, 1'b1, 3'd0});
      end
      valid_in = 1'b0; ena = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      sel = 0; data_in = 7'h4B; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      total++;
      if ({tx0, ready0, busy0, st0} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
         bad++;
         $display("FAIL t1_accept: {tx,ready,busy,state}=%b expected=%b",
                  {tx0, ready0, busy0, st0}, {1'b1, 1'b0, 1'b1, 3'd0});
      end
      step();
      total++;
      if ({tx0, st0, ready0} !== {1'b0, 3'd1, 1'b1}) begin
         bad++;
         $display("FAIL t1_load: {tx,state,ready}=%b expected=%b",
                  {tx0, st0, ready0}, {1'b0, 3'd1, 1'b1});
      end
      check_frame(7'h4B, 1, 1'b0, "t1_frame");
      total++;
      if ({tx0, st0, busy0} !== {1'b1, 3'd0, 1'b0}) begin
         bad++;
         $display("FAIL t1_idle: {tx,state,busy}=%b expected=%b",
                  {tx0, st0, busy0}, {1'b1, 3'd0, 1'b0});
      end
   endtask

   task automatic test_encode();
      do_reset();
      sel = 1; data_in = 7'h0B; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step();
      check_frame(7'h55, 1, 1'b0, "t2_encode");
      total++;
      if ({tx1, st1} !== {1'b1, 3'd0}) begin
         bad++;
         $display("FAIL t2_idle: {tx,state}=%b expected=%b", {tx1, st1}, {1'b1, 3'd0});
      end
      sel = 0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      sel = 0; data_in = 7'h01; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step();
      data_in = 7'h7E; valid_in = 1'b1;
      fork
         check_frame(7'h01, 1, 1'b0, "t3_frame1");
         begin
            step();
            valid_in = 1'b0;
            total++;
            if ({ready0, busy0} !== {1'b0, 1'b1}) begin
               bad++;
               $display("FAIL t3_hold_full: {ready,busy}=%b expected=%b",
                        {ready0, busy0}, {1'b0, 1'b1});
            end
         end
      join
      check_frame(7'h7E, 1, 1'b0, "t3_frame2");
      total++;
      if ({tx0, st0, busy0, ready0} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL t3_idle: {tx,state,busy,ready}=%b expected=%b",
                  {tx0, st0, busy0, ready0}, {1'b1, 3'd0, 1'b0, 1'b1});
      end
   endtask

   task automatic test_ena_toggle();
      do_reset();
      sel = 0; data_in = 7'h4B; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step();
      check_frame(7'h4B, 1, 1'b1, "t4_ena_toggle");
      total++;
      if ({tx0, st0} !== {1'b1, 3'd0}) begin
         bad++;
         $display("FAIL t4_idle: {tx,state}=%b expected=%b", {tx0, st0}, {1'b1, 3'd0});
      end
   endtask

   task automatic test_mid_reset();
      bit restarted;
      do_reset();
      sel = 0; data_in = 7'h4B; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step();
      data_in = 7'h2A; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      for (int i = 0; i < 33; i++) step();
      total++;
      if ({st0, ready0} !== {3'd2, 1'b0}) begin
         bad++;
         $display("FAIL t5_pre: {state,ready}=%b expected=%b", {st0, ready0}, {3'd2, 1'b0});
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total++;
      if ({tx0, st0, ready0, busy0} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL t5_reset: {tx,state,ready,busy}=%b expected=%b",
                  {tx0, st0, ready0, busy0}, {1'b1, 3'd0, 1'b1, 1'b0});
      end
      restarted = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (tx0 !== 1'b1) restarted = 1'b1;
         step();
      end
      total++;
      if (restarted) begin
         bad++;
         $display("FAIL t5_no_restart: tx went low=%b expected=0", restarted);
      end
   endtask

   task automatic test_loopback();
      logic [6:0] words [3];
      logic [6:0] rx_word;
      logic       start_s;
      bit         stops_ok, found, idle;
      words[0] = 7'h00; words[1] = 7'h7F; words[2] = 7'h2A;
      do_reset();
      sel = 2;
      for (int w = 0; w < 3; w++) begin
         data_in = words[w]; valid_in = 1'b1;
         step();
         valid_in = 1'b0;
         found = 1'b0;
         for (int i = 0; i < 20 && !found; i++) begin
            if (tx_sel === 1'b0) found = 1'b1;
            else step();
         end
         rx_word  = 7'h00;
         stops_ok = 1'b1;
         for (int i = 0; i < 4; i++) step();
         start_s = tx_sel;
         for (int b = 0; b < 7; b++) begin
            for (int i = 0; i < 8; i++) step();
            rx_word[b] = tx_sel;
         end
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) step();
            if (tx_sel !== 1'b1) stops_ok = 1'b0;
         end
         total++;
         if (!found || start_s !== 1'b0 || !stops_ok || rx_word !== words[w]) begin
            bad++;
            $display("FAIL t6_rx%0d: data=%h valid=%b expected data=%h valid=1",
                     w, rx_word, found && start_s === 1'b0 && stops_ok, words[w]);
         end
         idle = 1'b0;
         for (int i = 0; i < 40 && !idle; i++) begin
            if (busy2 === 1'b0 && st2 === 3'd0) idle = 1'b1;
            else step();
         end
         total++;
         if (!idle) begin
            bad++;
            $display("FAIL t6_idle%0d: busy=%b state=%0d expected busy=0 state=0", w, busy2, st2);
         end
      end
      sel = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; ena = 1'b1; valid_in = 1'b0; data_in = 7'h00;
      test_reset();
      test_ena_gate();
      test_basic();
      test_encode();
      test_back_to_back();
      test_ena_toggle();
      test_mid_reset();
      test_loopback();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
